// File: rtl/tmds_pkg.sv
// tmds_pkg: mode encodings, fixed TMDS tokens, TERC4 table and ones counter
// shared by the lane encoder. The TERC4 table and island guard token exist
// only when TMDS_DATA_ISLAND_EN is defined (DVI-only build otherwise).
package tmds_pkg;

    typedef enum logic [2:0] {
        MODE_CONTROL      = 3'd0,
        MODE_VIDEO        = 3'd1,
        MODE_VIDEO_GUARD  = 3'd2,
        MODE_ISLAND_GUARD = 3'd3,
        MODE_ISLAND_DATA  = 3'd4
    } tmdsMode_t;

    // Indexed by {C1,C0}.
    localparam logic [9:0] CONTROL_TOKENS [4] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    // Video guard band: roles 0 and 2 use the outer token, role 1 the middle one.
    localparam logic [9:0] VIDEO_GUARD_OUTER  = 10'b1011001100;
    localparam logic [9:0] VIDEO_GUARD_MIDDLE = 10'b0100110011;

`ifdef TMDS_DATA_ISLAND_EN
    localparam logic [9:0] ISLAND_GUARD_TOKEN = 10'b0100110011;

    localparam logic [9:0] TERC4_TABLE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
`endif

    function automatic logic [3:0] onesCount(input logic [7:0] value);
        logic [3:0] total;
        total = '0;
        for (int k = 0; k < 8; k++) begin
            total = total + {3'b000, value[k]};
        end
        return total;
    endfunction

endpackage

// File: rtl/tmds_video_lane.sv
// tmds_video_lane: one lane's transition-minimising stage (q_m) and the
// DC-balancing stage with its running-disparity register. The 10-bit video
// character is combinational from the stage-1 register; the top registers it.
module tmds_video_lane
    import tmds_pkg::*;
(
    input  logic       pixelClock,
    input  logic       reset,
    input  logic       sampleEnable,
    input  logic [7:0] pixelData,
    input  logic       stageValid,
    input  logic       stageIsVideo,
    output logic [9:0] videoCharacter
);

    logic [3:0]        dataOnes;
    logic              useXnor;
    logic [8:0]        qmNext;
    logic [8:0]        stageQm;
    logic [3:0]        qmOnes;
    logic signed [4:0] qmBalance;
    logic signed [4:0] twiceQm8;
    logic signed [4:0] twiceNotQm8;
    logic signed [4:0] disparity;
    logic signed [4:0] nextDisparity;

    assign dataOnes = onesCount(pixelData);
    assign useXnor  = (dataOnes > 4'd4) || ((dataOnes == 4'd4) && !pixelData[0]);

    // Build q_m by XOR/XNOR chaining from bit 0 upwards.
    always_comb begin : qmChain
        logic chain;
        qmNext    = '0;
        chain     = pixelData[0];
        qmNext[0] = chain;
        for (int k = 1; k < 8; k++) begin
            chain     = useXnor ? ~(chain ^ pixelData[k]) : (chain ^ pixelData[k]);
            qmNext[k] = chain;
        end
        qmNext[8] = ~useXnor;
    end

    // Stage-1 register: only a valid slot loads a new q_m.
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            stageQm <= '0;
        end else if (sampleEnable) begin
            stageQm <= qmNext;
        end
    end

    // N1 - N0 of q_m[7:0] equals 2*N1 - 8; modular 5-bit arithmetic is exact here.
    assign qmOnes      = onesCount(stageQm[7:0]);
    assign qmBalance   = {qmOnes, 1'b0} - 5'd8;
    assign twiceQm8    = {3'b000, stageQm[8], 1'b0};
    assign twiceNotQm8 = {3'b000, ~stageQm[8], 1'b0};

    // Stage-2 DC balancing: pick inversion and the disparity update.
    always_comb begin
        videoCharacter = {1'b0, stageQm[8], stageQm[7:0]};
        nextDisparity  = disparity - twiceNotQm8 + qmBalance;
        if ((disparity == 5'sd0) || (qmOnes == 4'd4)) begin
            videoCharacter = {~stageQm[8], stageQm[8], stageQm[8] ? stageQm[7:0] : ~stageQm[7:0]};
            nextDisparity  = stageQm[8] ? (disparity + qmBalance) : (disparity - qmBalance);
        end else if (((disparity > 5'sd0) && (qmBalance > 5'sd0)) ||
                     ((disparity < 5'sd0) && (qmBalance < 5'sd0))) begin
            videoCharacter = {1'b1, stageQm[8], ~stageQm[7:0]};
            nextDisparity  = disparity + twiceQm8 - qmBalance;
        end
    end

    // Running disparity: advances on video slots, clears on any other valid slot.
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            disparity <= '0;
        end else if (stageValid) begin
            disparity <= stageIsVideo ? nextDisparity : 5'sd0;
        end
    end

endmodule

// File: rtl/tmds_lane_encoder.sv
// tmds_lane_encoder: NUM_CHANNELS-lane TMDS encoder with a two-register,
// valid-qualified pipeline. Lane i plays HDMI channel role (i mod 3) for
// guard bands. Define TMDS_DATA_ISLAND_EN to add the TERC4 data-island
// modes; without it modes 3 and 4 fall back to control tokens (DVI only).
module tmds_lane_encoder
    import tmds_pkg::*;
#(
    parameter int NUM_CHANNELS = 3
) (
    input  logic                        pixelClock,
    input  logic                        reset,
    input  logic                        inValid,
    input  logic [2:0]                  mode,
    input  logic [8*NUM_CHANNELS-1:0]   pixelData,
    input  logic [2*NUM_CHANNELS-1:0]   controlBus,
    input  logic [4*NUM_CHANNELS-1:0]   islandData,
    output logic [10*NUM_CHANNELS-1:0]  tmdsCharacters,
    output logic                        outValid
);

    logic                        stageValid;
    logic [2:0]                  stageMode;
    logic [2*NUM_CHANNELS-1:0]   stageControl;
    logic                        stageIsVideo;
    logic [10*NUM_CHANNELS-1:0]  nextChars;

`ifdef TMDS_DATA_ISLAND_EN
    logic [4*NUM_CHANNELS-1:0]   stageIsland;

    // Stage-1 side-band carrying the island nibbles alongside q_m.
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            stageIsland <= '0;
        end else if (inValid) begin
            stageIsland <= islandData;
        end
    end
`else
    logic unusedIslandBits;
    assign unusedIslandBits = ^islandData;
`endif

    // Stage-1 side-band: mode and control bits travel with the slot.
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            stageValid   <= 1'b0;
            stageMode    <= MODE_CONTROL;
            stageControl <= '0;
        end else begin
            stageValid <= inValid;
            if (inValid) begin
                stageMode    <= mode;
                stageControl <= controlBus;
            end
        end
    end

    assign stageIsVideo = (stageMode == MODE_VIDEO);

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : gLane
        localparam int ROLE = i % 3;

        logic [9:0] videoChar;
        logic [9:0] laneChar;

        tmds_video_lane uVideoLane (
            .pixelClock     (pixelClock),
            .reset          (reset),
            .sampleEnable   (inValid),
            .pixelData      (pixelData[8*i +: 8]),
            .stageValid     (stageValid),
            .stageIsVideo   (stageIsVideo),
            .videoCharacter (videoChar)
        );

        // Per-lane mode mux; unknown modes fall through to control tokens.
        always_comb begin
            laneChar = CONTROL_TOKENS[stageControl[2*i +: 2]];
            case (stageMode)
                MODE_VIDEO:       laneChar = videoChar;
                MODE_VIDEO_GUARD: laneChar = (ROLE == 1) ? VIDEO_GUARD_MIDDLE : VIDEO_GUARD_OUTER;
`ifdef TMDS_DATA_ISLAND_EN
                MODE_ISLAND_GUARD: laneChar = (ROLE == 0) ? TERC4_TABLE[{2'b11, stageControl[2*i +: 2]}]
                                                          : ISLAND_GUARD_TOKEN;
                MODE_ISLAND_DATA:  laneChar = TERC4_TABLE[stageIsland[4*i +: 4]];
`endif
                default: ;
            endcase
        end

        assign nextChars[10*i +: 10] = laneChar;
    end

    // Output register: characters hold across invalid slots, valid follows stage 1.
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            tmdsCharacters <= '0;
            outValid       <= 1'b0;
        end else begin
            outValid <= stageValid;
            if (stageValid) begin
                tmdsCharacters <= nextChars;
            end
        end
    end

endmodule

// File: tb/tb_tmds_lane_encoder.sv
// Scoreboard bench for tmds_lane_encoder with six lanes (two of each role).
// Expected characters are hand-derived; the island expectations follow
// whether TMDS_DATA_ISLAND_EN is defined for the build.
module tb_tmds_lane_encoder;

    localparam int N = 6;

    localparam logic [2:0] M_CTRL = 3'd0;
    localparam logic [2:0] M_VID  = 3'd1;
    localparam logic [2:0] M_VG   = 3'd2;
    localparam logic [2:0] M_IG   = 3'd3;
    localparam logic [2:0] M_ID   = 3'd4;

    localparam logic [9:0] C00   = 10'b1101010100;
    localparam logic [9:0] C01   = 10'b0010101011;
    localparam logic [9:0] C10   = 10'b0101010100;
    localparam logic [9:0] C11   = 10'b1010101011;
    localparam logic [9:0] V00A  = 10'b0100000000;
    localparam logic [9:0] VONES = 10'b1111111111;
    localparam logic [9:0] VFF1  = 10'b0011111111;
    localparam logic [9:0] VFF2  = 10'b1000000000;
    localparam logic [9:0] V55   = 10'b0100110011;
    localparam logic [9:0] VAA   = 10'b1000110011;
    localparam logic [9:0] GA    = 10'b1011001100;
    localparam logic [9:0] GB    = 10'b0100110011;

    logic                pixelClock = 1'b0;
    logic                reset;
    logic                inValid;
    logic [2:0]          mode;
    logic [8*N-1:0]      pixelData;
    logic [2*N-1:0]      controlBus;
    logic [4*N-1:0]      islandData;
    logic [10*N-1:0]     tmdsCharacters;
    logic                outValid;

    typedef struct {
        logic [10*N-1:0] want;
        int              tag;
    } expItem_t;

    expItem_t expQ[$];
    int checks = 0;
    int errors = 0;

    tmds_lane_encoder #(.NUM_CHANNELS(N)) dut (
        .pixelClock     (pixelClock),
        .reset          (reset),
        .inValid        (inValid),
        .mode           (mode),
        .pixelData      (pixelData),
        .controlBus     (controlBus),
        .islandData     (islandData),
        .tmdsCharacters (tmdsCharacters),
        .outValid       (outValid)
    );

    initial forever #5 pixelClock = ~pixelClock;

    function automatic logic [10*N-1:0] rep6(input logic [9:0] c);
        return {6{c}};
    endfunction

    task automatic check(input string name, input logic [10*N-1:0] got, input logic [10*N-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic slot(input logic [2:0] m, input logic [8*N-1:0] pd, input logic [2*N-1:0] cb,
                        input logic [4*N-1:0] isl, input bit push, input logic [10*N-1:0] want, input int tag);
        mode       = m;
        pixelData  = pd;
        controlBus = cb;
        islandData = isl;
        inValid    = 1'b1;
        if (push) expQ.push_back('{want, tag});
        @(negedge pixelClock);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        inValid = 1'b0;
        while (expQ.size() != 0 && n < 20) begin
            @(negedge pixelClock);
            n++;
        end
        @(negedge pixelClock);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL %s pending=%0d want=0", name, expQ.size());
        end
    endtask

    // Monitor: every presented character set is matched against the queue head.
    initial begin
        expItem_t item;
        forever begin
            @(negedge pixelClock);
            if (!reset && outValid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got=%h want=none", tmdsCharacters);
                end else begin
                    item = expQ.pop_front();
                    check($sformatf("slot%0d", item.tag), tmdsCharacters, item.want);
                end
            end
        end
    end

    initial begin
        logic [10*N-1:0] igA, igB, idA, idB;
`ifdef TMDS_DATA_ISLAND_EN
        igA = {10'b0100110011, 10'b0100110011, 10'b1010001110,
               10'b0100110011, 10'b0100110011, 10'b1010001110};
        igB = {10'b0100110011, 10'b0100110011, 10'b1001110001,
               10'b0100110011, 10'b0100110011, 10'b0101100011};
        idA = rep6(10'b1010011100);
        idB = {10'b1010001110, 10'b0100011110, 10'b1011000011,
               10'b1011100100, 10'b1001100011, 10'b1010011100};
`else
        igA = rep6(C00);
        igB = {C11, C11, C01, C11, C11, C10};
        idA = rep6(C11);
        idB = rep6(C11);
`endif
        reset = 1'b1; inValid = 1'b0; mode = M_CTRL;
        pixelData = '0; controlBus = '0; islandData = '0;
        repeat (3) @(negedge pixelClock);
        check("reset_chars", tmdsCharacters, '0);
        check("reset_valid", {{(10*N-1){1'b0}}, outValid}, '0);
        reset = 1'b0;

        // Disparity walk from zero: -8, +2, -6.
        slot(M_VID, '0, '0, '0, 1, rep6(V00A), 1);
        slot(M_VID, '0, '0, '0, 1, rep6(VONES), 2);
        slot(M_VID, '0, '0, '0, 1, rep6(V00A), 3);

        // Gap with junk on the inputs: nothing may move.
        inValid = 1'b0; mode = M_CTRL; pixelData = {N{8'hFF}}; controlBus = '1;
        for (int i = 0; i < 5; i++) begin
            @(negedge pixelClock);
            if (i >= 1) begin
                check("gap_valid", {{(10*N-1){1'b0}}, outValid}, '0);
                check("gap_hold", tmdsCharacters, rep6(V00A));
            end
        end

        // Resume from cnt=-6: -> +4, -4, +2, -6.
        slot(M_VID, '0, '0, '0, 1, rep6(VONES), 4);
        slot(M_VID, '0, '0, '0, 1, rep6(V00A), 5);
        slot(M_VID, {N{8'hFF}}, '0, '0, 1, rep6(VFF1), 6);
        slot(M_VID, {N{8'hFF}}, '0, '0, 1, rep6(VFF2), 7);

        // Control tokens per lane, then video restarts from cnt=0.
        slot(M_CTRL, '0, {2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01}, '0, 1,
             {C00, C01, C11, C10, C00, C01}, 8);
        slot(M_VID, '0, '0, '0, 1, rep6(V00A), 9);
        slot(3'd5, '0, '1, '0, 1, rep6(C11), 10);
        slot(3'd7, '0, '0, '0, 1, rep6(C00), 11);

        // Mixed data per lane; lanes 2 and 5 end at cnt=-8, the rest at 0.
        slot(M_VID, {8'h00, 8'hAA, 8'h55, 8'h00, 8'hAA, 8'h55}, '0, '0, 1,
             {V00A, VAA, V55, V00A, VAA, V55}, 12);
        slot(M_VID, {N{8'h55}}, '0, '0, 1, rep6(V55), 13);
        slot(M_VID, {N{8'hAA}}, '0, '0, 1, rep6(VAA), 14);
        slot(M_VID, '0, '0, '0, 1, {VONES, V00A, V00A, VONES, V00A, V00A}, 15);

        // Guard bands and islands.
        slot(M_VG, '0, '0, '0, 1, {GA, GB, GA, GA, GB, GA}, 16);
        slot(M_IG, '0, '0, '0, 1, igA, 17);
        slot(M_IG, '0, {2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b10}, '0, 1, igB, 18);
        slot(M_ID, '0, '1, '0, 1, idA, 19);
        slot(M_ID, '0, '1, {4'hC, 4'h5, 4'hF, 4'h2, 4'h1, 4'h0}, 1, idB, 20);

        // Video after island starts at 0 and ends at cnt=-6.
        slot(M_VID, '0, '0, '0, 1, rep6(V00A), 21);
        slot(M_VID, '0, '0, '0, 1, rep6(VONES), 22);
        slot(M_VID, '0, '0, '0, 1, rep6(V00A), 23);
        drain("drain_before_reset");

        // Reset with two slots in flight.
        slot(M_VID, '0, '0, '0, 0, '0, 0);
        reset = 1'b1;
        @(negedge pixelClock);
        check("midreset_chars", tmdsCharacters, '0);
        check("midreset_valid", {{(10*N-1){1'b0}}, outValid}, '0);
        reset = 1'b0;
        inValid = 1'b0;
        @(negedge pixelClock);
        check("postreset_valid", {{(10*N-1){1'b0}}, outValid}, '0);
        slot(M_VID, '0, '0, '0, 1, rep6(V00A), 24);
        slot(M_VID, '0, '0, '0, 1, rep6(VONES), 25);
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
